// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the R22SDF FFT output, ping-pong over two banks.
// Optional macro FFT_REORDER_FRAME_ID_EN adds o_frame_id (frames fully emitted before the current one).
module fft_bitrev_reorder #(
  parameter int DWIDTH = 32,
  parameter int LOG_N  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [LOG_N-1:0]  o_index,
  output logic              o_last,
  output logic              o_overflow
`ifdef FFT_REORDER_FRAME_ID_EN
  ,
  output logic [7:0]        o_frame_id
`endif
);

  // Handshake: i_valid has no ready, so input is never stalled and samples that
  // find no free bank are dropped. On the output, a sample transfers on a rising
  // edge where o_valid && i_ready; o_data/o_index/o_last hold until that edge.

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST = '1;

  typedef enum logic {IDLE, READ} state_t;

  state_t             state, state_next;
  logic [DWIDTH-1:0]  mem [2][N];
  logic [LOG_N-1:0]   w_cnt, r_cnt;
  logic               w_bank, r_bank;
  logic [1:0]         full, full_next;
  logic               load, last_load, w_ok, w_take;
`ifdef FFT_REORDER_FRAME_ID_EN
  logic [7:0]         frame_cnt;
`endif

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
    return r;
  endfunction

  // The output register only reloads when it is empty or being drained this cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (full[r_bank] && (!o_valid || i_ready)) begin
          load       = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (!o_valid || i_ready) begin
          load = 1'b1;
          if (r_cnt == LAST) state_next = full[~r_bank] ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A bank released by the reader on this edge is already writable.
  always_comb begin
    last_load = load && (r_cnt == LAST);
    w_ok      = !full[w_bank] || (last_load && (r_bank == w_bank));
    w_take    = i_valid && w_ok;
    full_next = full;
    if (last_load) full_next[r_bank] = 1'b0;
    if (w_take && (w_cnt == LAST)) full_next[w_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_take) mem[w_bank][bitrev(w_cnt)] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      w_cnt      <= '0;
      r_cnt      <= '0;
      w_bank     <= 1'b0;
      r_bank     <= 1'b0;
      full       <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_index    <= '0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
`ifdef FFT_REORDER_FRAME_ID_EN
      frame_cnt  <= '0;
      o_frame_id <= '0;
`endif
    end else begin
      state <= state_next;
      full  <= full_next;
      if (w_take) begin
        w_cnt <= w_cnt + 1'b1;
        if (w_cnt == LAST) w_bank <= ~w_bank;
      end
      if (i_valid && !w_ok) o_overflow <= 1'b1;
      if (load) begin
        o_data  <= mem[r_bank][r_cnt];
        o_index <= r_cnt;
        o_last  <= (r_cnt == LAST);
        o_valid <= 1'b1;
`ifdef FFT_REORDER_FRAME_ID_EN
        o_frame_id <= frame_cnt;
        if (last_load) frame_cnt <= frame_cnt + 1'b1;
`endif
        if (last_load) begin
          r_cnt  <= '0;
          r_bank <= ~r_bank;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
